// File: rtl/mesi_snoop_cache.sv
// mesi_snoop_cache: direct-mapped MESI snooping cache controller
// with bus arbitration, dirty-victim writeback and hit/miss counters.
module mesi_snoop_cache #(
  parameter int LINES  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [2:0]        bus_cmd,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_resp_valid,
  input  logic [DATA_W-1:0] bus_resp_data,
  input  logic              bus_resp_shared,
  input  logic [2:0]        snoop_cmd,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_shared,
  output logic              snoop_flush,
  output logic [DATA_W-1:0] snoop_data,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_RD    = 3'd1;
  localparam logic [2:0] C_RDX   = 3'd2;
  localparam logic [2:0] C_UPGR  = 3'd3;
  localparam logic [2:0] C_FLUSH = 3'd4;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WB, MISS, FILL, UPGR, DONE
  } fsm_t;

  fsm_t fsm;

  logic [1:0]        line_st   [LINES];
  logic [TAG_W-1:0]  line_tag  [LINES];
  logic [DATA_W-1:0] line_data [LINES];

  logic              cur_write;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;

  logic [IDX_W-1:0] ri;
  logic [TAG_W-1:0] rt;
  logic [1:0]       cur_st;
  logic             hit;

  logic [IDX_W-1:0] s_idx;
  logic [TAG_W-1:0] s_tag;
  logic [1:0]       s_st;
  logic [1:0]       s_next;
  logic             s_hit;
  logic             s_upd;
  logic             s_flush;
  logic             s_shared;

  logic kill;
  logic lost;
  logic gnt_ok;

  assign ri     = cur_addr[IDX_W-1:0];
  assign rt     = cur_addr[ADDR_W-1:IDX_W];
  assign cur_st = line_st[ri];
  assign hit    = (cur_st != ST_I) && (line_tag[ri] == rt);
  assign s_idx  = snoop_addr[IDX_W-1:0];
  assign s_tag  = snoop_addr[ADDR_W-1:IDX_W];
  assign kill   = s_upd && (s_idx == ri);
  assign gnt_ok = bus_req && bus_gnt && !lost;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Snoop decode: next line state and the responses to register
  always_comb begin
    s_st     = line_st[s_idx];
    s_hit    = (snoop_cmd != C_NONE) && (s_st != ST_I) &&
               (line_tag[s_idx] == s_tag);
    s_next   = s_st;
    s_flush  = 1'b0;
    s_shared = 1'b0;
    if (s_hit) begin
      case (snoop_cmd)
        C_RD: begin
          s_next   = ST_S;
          s_flush  = (s_st == ST_M);
          s_shared = 1'b1;
        end
        C_RDX: begin
          s_next   = ST_I;
          s_flush  = (s_st == ST_M);
          s_shared = 1'b1;
        end
        C_UPGR: begin
          if (s_st == ST_S) s_next = ST_I;
        end
        default: ;
      endcase
    end
    s_upd = s_hit && (s_next != s_st);
  end

  // A pending flush or upgrade is abandoned once a snoop took the line
  always_comb begin
    lost = 1'b0;
    if (fsm == WB)
      lost = (cur_st != ST_M) || kill;
    else if (fsm == UPGR)
      lost = (cur_st != ST_S) || kill;
  end

  // Bus command is driven only in the granted cycle
  always_comb begin
    bus_cmd   = C_NONE;
    bus_addr  = '0;
    bus_wdata = '0;
    if (gnt_ok) begin
      case (fsm)
        WB: begin
          bus_cmd   = C_FLUSH;
          bus_addr  = {line_tag[ri], ri};
          bus_wdata = line_data[ri];
        end
        MISS: begin
          bus_cmd  = cur_write ? C_RDX : C_RD;
          bus_addr = cur_addr;
        end
        UPGR: begin
          bus_cmd  = C_UPGR;
          bus_addr = cur_addr;
        end
        default: ;
      endcase
    end
  end

  // Registered snoop responses, one cycle after the snooped command
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      snoop_shared <= 1'b0;
      snoop_flush  <= 1'b0;
      snoop_data   <= '0;
    end else begin
      snoop_shared <= s_shared;
      snoop_flush  <= s_flush;
      snoop_data   <= s_flush ? line_data[s_idx] : '0;
    end
  end

  // Line array and request FSM; FSM writes follow snoop writes so a fill wins
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < LINES; i++) begin
        line_st[i]   <= ST_I;
        line_tag[i]  <= '0;
        line_data[i] <= '0;
      end
      fsm        <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      bus_req    <= 1'b0;
      cur_write  <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (s_upd) line_st[s_idx] <= s_next;
      case (fsm)
        IDLE: begin
          if (req_valid) begin
            cur_write <= req_write;
            cur_addr  <= req_addr;
            cur_wdata <= req_wdata;
            req_ready <= 1'b0;
            fsm       <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!kill) begin
            if (hit) begin
              hit_count <= sat_inc(hit_count);
              if (!cur_write) begin
                rsp_data  <= line_data[ri];
                rsp_valid <= 1'b1;
                fsm       <= DONE;
              end else if (cur_st != ST_S) begin
                line_data[ri] <= cur_wdata;
                line_st[ri]   <= ST_M;
                rsp_data      <= cur_wdata;
                rsp_valid     <= 1'b1;
                fsm           <= DONE;
              end else begin
                bus_req <= 1'b1;
                fsm     <= UPGR;
              end
            end else begin
              miss_count <= sat_inc(miss_count);
              bus_req    <= 1'b1;
              fsm        <= (cur_st == ST_M) ? WB : MISS;
            end
          end
        end
        WB: begin
          if (lost) begin
            fsm <= MISS;
          end else if (gnt_ok) begin
            line_st[ri] <= ST_I;
            fsm         <= MISS;
          end
        end
        MISS: begin
          if (gnt_ok) begin
            bus_req <= 1'b0;
            fsm     <= FILL;
          end
        end
        FILL: begin
          if (bus_resp_valid) begin
            line_tag[ri] <= rt;
            if (cur_write) begin
              line_data[ri] <= cur_wdata;
              line_st[ri]   <= ST_M;
              rsp_data      <= cur_wdata;
            end else begin
              line_data[ri] <= bus_resp_data;
              line_st[ri]   <= bus_resp_shared ? ST_S : ST_E;
              rsp_data      <= bus_resp_data;
            end
            rsp_valid <= 1'b1;
            fsm       <= DONE;
          end
        end
        UPGR: begin
          if (lost) begin
            miss_count <= sat_inc(miss_count);
            fsm        <= MISS;
          end else if (gnt_ok) begin
            line_st[ri]   <= ST_M;
            line_data[ri] <= cur_wdata;
            rsp_data      <= cur_wdata;
            rsp_valid     <= 1'b1;
            bus_req       <= 1'b0;
            fsm           <= DONE;
          end
        end
        DONE: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          fsm       <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mesi_snoop_cache.sv
// tb_mesi_snoop_cache: directed table-driven bench for the
// MESI snooping cache controller.
module tb_mesi_snoop_cache;
  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_RD    = 3'd1;
  localparam logic [2:0] C_RDX   = 3'd2;
  localparam logic [2:0] C_UPGR  = 3'd3;
  localparam logic [2:0] C_FLUSH = 3'd4;

  logic       clock = 1'b0;
  logic       clear;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [4:0] req_addr;
  logic [2:0] req_wdata;
  logic       rsp_valid;
  logic [2:0] rsp_data;
  logic       bus_req;
  logic       bus_gnt;
  logic [2:0] bus_cmd;
  logic [4:0] bus_addr;
  logic [2:0] bus_wdata;
  logic       bus_resp_valid;
  logic [2:0] bus_resp_data;
  logic       bus_resp_shared;
  logic [2:0] snoop_cmd;
  logic [4:0] snoop_addr;
  logic       snoop_shared;
  logic       snoop_flush;
  logic [2:0] snoop_data;
  logic [7:0] hit_count;
  logic [7:0] miss_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       wr;
    logic [4:0] addr;
    logic [2:0] wd;
    logic       sh;
    logic [2:0] fill;
    logic [2:0] exp_data;
    logic [5:0] exp_cmds;
    logic [4:0] exp_faddr;
    logic [2:0] exp_fdata;
    logic [1:0] exp_st;
    int         exp_lat;
    int         exp_hit;
    int         exp_miss;
  } vec_t;

  vec_t vecs [7];

  mesi_snoop_cache dut (
    .clock           (clock),
    .clear           (clear),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .bus_req         (bus_req),
    .bus_gnt         (bus_gnt),
    .bus_cmd         (bus_cmd),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_resp_valid  (bus_resp_valid),
    .bus_resp_data   (bus_resp_data),
    .bus_resp_shared (bus_resp_shared),
    .snoop_cmd       (snoop_cmd),
    .snoop_addr      (snoop_addr),
    .snoop_shared    (snoop_shared),
    .snoop_flush     (snoop_flush),
    .snoop_data      (snoop_data),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request and act as arbiter/memory until rsp_valid.
  task automatic run_req(input logic wr, input logic [4:0] a,
                         input logic [2:0] wd, input logic sh,
                         input logic [2:0] fill, input logic snp,
                         output logic [2:0] rd, output int lat,
                         output logic [5:0] cmds,
                         output logic [4:0] faddr,
                         output logic [2:0] fdata);
    int n;
    int nc;
    logic pend;
    logic snp_done;
    cmds = '0;
    faddr = '0;
    fdata = '0;
    nc = 0;
    pend = 1'b0;
    snp_done = !snp;
    @(negedge clock);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 200) begin
      bus_gnt = 1'b0;
      bus_resp_valid = 1'b0;
      snoop_cmd = C_NONE;
      if (pend) begin
        bus_resp_valid  = 1'b1;
        bus_resp_data   = fill;
        bus_resp_shared = sh;
        pend = 1'b0;
      end else if (bus_req && !snp_done) begin
        snoop_cmd  = C_UPGR;
        snoop_addr = a;
        snp_done   = 1'b1;
      end else if (bus_req) begin
        bus_gnt = 1'b1;
        #1;
        if (nc == 0) cmds[5:3] = bus_cmd;
        else if (nc == 1) cmds[2:0] = bus_cmd;
        nc++;
        if (bus_cmd == C_FLUSH) begin
          faddr = bus_addr;
          fdata = bus_wdata;
        end
        if (bus_cmd == C_RD || bus_cmd == C_RDX) pend = 1'b1;
      end
      @(negedge clock);
      n++;
    end
    bus_gnt = 1'b0;
    bus_resp_valid = 1'b0;
    snoop_cmd = C_NONE;
    chk("req_done", rsp_valid, 1'b1);
    rd  = rsp_data;
    lat = n;
  endtask

  task automatic snoop_op(input logic [2:0] cmd, input logic [4:0] a);
    @(negedge clock);
    snoop_cmd  = cmd;
    snoop_addr = a;
    @(negedge clock);
    snoop_cmd  = C_NONE;
  endtask

  task automatic start_miss(input logic [4:0] a);
    int n;
    @(negedge clock);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = a;
    req_wdata = '0;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (!bus_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("miss_bus_req", bus_req, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rd;
    int         lat;
    logic [5:0] cmds;
    logic [4:0] fa;
    logic [2:0] fd;
    int         nv;

    vecs[0] = '{1'b0, 5'b00110, 3'd0, 1'b0, 3'b101, 3'b101,
                6'b001_000, 5'd0, 3'd0, 2'b10, 0, 0, 1};
    vecs[1] = '{1'b0, 5'b00110, 3'd0, 1'b0, 3'b000, 3'b101,
                6'b000_000, 5'd0, 3'd0, 2'b10, 2, 1, 1};
    vecs[2] = '{1'b1, 5'b00110, 3'b011, 1'b0, 3'b000, 3'b011,
                6'b000_000, 5'd0, 3'd0, 2'b11, 2, 2, 1};
    vecs[3] = '{1'b0, 5'b01010, 3'd0, 1'b1, 3'b100, 3'b100,
                6'b100_001, 5'b00110, 3'b011, 2'b01, 0, 2, 2};
    vecs[4] = '{1'b1, 5'b01010, 3'b111, 1'b0, 3'b000, 3'b111,
                6'b011_000, 5'd0, 3'd0, 2'b11, 0, 3, 2};
    vecs[5] = '{1'b0, 5'b00001, 3'd0, 1'b1, 3'b010, 3'b010,
                6'b001_000, 5'd0, 3'd0, 2'b01, 0, 3, 3};
    vecs[6] = '{1'b1, 5'b10001, 3'b110, 1'b0, 3'b000, 3'b110,
                6'b010_000, 5'd0, 3'd0, 2'b11, 0, 3, 4};

    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    bus_gnt = 1'b0;
    bus_resp_valid = 1'b0;
    bus_resp_data = '0;
    bus_resp_shared = 1'b0;
    snoop_cmd = C_NONE;
    snoop_addr = '0;
    clear = 1'b0;

    repeat (3) @(negedge clock);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_bus_cmd", bus_cmd, C_NONE);
    chk("rst_snoop_shared", snoop_shared, 1'b0);
    chk("rst_hit", hit_count, 8'd0);
    chk("rst_miss", miss_count, 8'd0);
    clear = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_req(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].sh,
              vecs[i].fill, 1'b0, rd, lat, cmds, fa, fd);
      chk($sformatf("v%0d_rsp_data", i), rd, vecs[i].exp_data);
      chk($sformatf("v%0d_cmds", i), cmds, vecs[i].exp_cmds);
      chk($sformatf("v%0d_flush_addr", i), fa, vecs[i].exp_faddr);
      chk($sformatf("v%0d_flush_data", i), fd, vecs[i].exp_fdata);
      chk($sformatf("v%0d_state", i),
          dut.line_st[vecs[i].addr[1:0]], vecs[i].exp_st);
      chk($sformatf("v%0d_hit", i), hit_count, vecs[i].exp_hit);
      chk($sformatf("v%0d_miss", i), miss_count, vecs[i].exp_miss);
      if (vecs[i].exp_lat != 0)
        chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
    end

    snoop_op(C_RD, 5'b10001);
    chk("snp_rd_m_shared", snoop_shared, 1'b1);
    chk("snp_rd_m_flush", snoop_flush, 1'b1);
    chk("snp_rd_m_data", snoop_data, 3'b110);
    chk("snp_rd_m_state", dut.line_st[1], 2'b01);

    snoop_op(C_RDX, 5'b10001);
    chk("snp_rdx_s_shared", snoop_shared, 1'b1);
    chk("snp_rdx_s_flush", snoop_flush, 1'b0);
    chk("snp_rdx_s_state", dut.line_st[1], 2'b00);

    snoop_op(C_RD, 5'b11110);
    chk("snp_miss_shared", snoop_shared, 1'b0);
    chk("snp_miss_flush", snoop_flush, 1'b0);
    chk("snp_miss_state", dut.line_st[2], 2'b11);

    snoop_op(C_RD, 5'b01010);
    chk("snp_rd_m2_flush", snoop_flush, 1'b1);
    chk("snp_rd_m2_data", snoop_data, 3'b111);
    chk("snp_rd_m2_state", dut.line_st[2], 2'b01);

    run_req(1'b1, 5'b01010, 3'b101, 1'b0, 3'b000, 1'b1,
            rd, lat, cmds, fa, fd);
    chk("upg_conv_rsp", rd, 3'b101);
    chk("upg_conv_cmds", cmds, 6'b010_000);
    chk("upg_conv_hit", hit_count, 8'd4);
    chk("upg_conv_miss", miss_count, 8'd5);
    chk("upg_conv_state", dut.line_st[2], 2'b11);

    start_miss(5'b00011);
    clear = 1'b0;
    #1;
    chk("rst_miss_bus_req", bus_req, 1'b0);
    chk("rst_miss_bus_cmd", bus_cmd, C_NONE);
    chk("rst_miss_hit", hit_count, 8'd0);
    chk("rst_miss_miss", miss_count, 8'd0);
    nv = 0;
    for (int i = 0; i < 4; i++)
      if (dut.line_st[i] != 2'b00) nv++;
    chk("rst_lines_invalid", nv, 0);
    @(negedge clock);
    clear = 1'b1;

    start_miss(5'b00011);
    bus_gnt = 1'b1;
    @(negedge clock);
    bus_gnt = 1'b0;
    clear = 1'b0;
    #1;
    chk("rst_fill_bus_req", bus_req, 1'b0);
    chk("rst_fill_req_ready", req_ready, 1'b1);
    chk("rst_fill_rsp_valid", rsp_valid, 1'b0);
    chk("rst_fill_miss", miss_count, 8'd0);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", req_ready, 1'b1);

    run_req(1'b0, 5'b00110, 3'd0, 1'b0, 3'b101, 1'b0,
            rd, lat, cmds, fa, fd);
    chk("post_rst_cmds", cmds, 6'b001_000);
    chk("post_rst_miss", miss_count, 8'd1);
    chk("post_rst_hit", hit_count, 8'd0);
    chk("post_rst_state", dut.line_st[2], 2'b10);

    for (int k = 0; k < 260; k++)
      run_req(1'b0, 5'b00110, 3'd0, 1'b0, 3'b000, 1'b0,
              rd, lat, cmds, fa, fd);
    chk("sat_hit", hit_count, 8'd255);
    chk("sat_miss", miss_count, 8'd1);
    chk("sat_rsp", rd, 3'b101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
